// File: rtl/ti_packet_receiver.sv
// Task Injector NoC ingress: captures the fixed-size packet header, classifies the
// service word, and streams payload flits to the injector FSM through a small FIFO.
// Packets whose size field cannot even cover the header are drained and flagged.
module ti_packet_receiver #(
    parameter int HEADER_SIZE    = 13,
    parameter int PLD_FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    input  logic [31:0]                   data_i,
    output logic                          credit_o,
    output logic                          hdr_valid_o,
    input  logic                          hdr_ack_i,
    output logic [32*HEADER_SIZE-1:0]     hdr_o,
    output logic [31:0]                   service_o,
    output logic                          svc_known_o,
    output logic [31:0]                   pld_len_o,
    output logic [31:0]                   pld_data_o,
    output logic                          pld_last_o,
    output logic                          pld_valid_o,
    input  logic                          pld_ready_i,
    output logic                          err_size_o
);

    localparam int CNT_W = $clog2(HEADER_SIZE);
    localparam int PTR_W = $clog2(PLD_FIFO_DEPTH);
    // size counts flits after flit1, so the header alone needs HEADER_SIZE-2 of them
    localparam logic [31:0]      MIN_SIZE = 32'(HEADER_SIZE - 2);
    localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HEADER_SIZE - 1);
    localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(PLD_FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_HEADER   = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_DISCARD  = 2'd3
    } state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } pld_t;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [31:0]                       rem_q, rem_d;
    logic [HEADER_SIZE-1:0][31:0]      hdr_q, hdr_d;
    logic                              hdr_valid_q, hdr_valid_d;
    logic                              err_q, err_d;
    pld_t [PLD_FIFO_DEPTH-1:0]         mem_q, mem_d;
    logic [PTR_W-1:0]                  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]                    occ_q, occ_d;

    logic        credit, push, push_last, pop, fifo_full;
    logic [31:0] raw_len;

    assign raw_len   = hdr_q[1] - MIN_SIZE;
    assign fifo_full = (occ_q == FULL_OCC);
    assign pop       = (occ_q != '0) && pld_ready_i;

    // Packet parser: header capture, size check, payload/discard countdown
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        hdr_d       = hdr_q;
        hdr_valid_d = hdr_valid_q;
        err_d       = 1'b0;
        credit      = 1'b0;
        push        = 1'b0;
        push_last   = 1'b0;
        case (state_q)
            S_HEADER: begin
                credit = 1'b1;
                if (rx_i) begin
                    hdr_d[cnt_q] = data_i;
                    if (cnt_q == CNT_W'(1) && data_i < MIN_SIZE) begin
                        // short packet: drop whatever follows the size flit
                        err_d = 1'b1;
                        cnt_d = '0;
                        rem_d = data_i;
                        if (data_i != '0) state_d = S_DISCARD;
                    end else if (cnt_q == LAST_HDR) begin
                        cnt_d       = '0;
                        hdr_valid_d = 1'b1;
                        state_d     = S_WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                if (hdr_ack_i) begin
                    hdr_valid_d = 1'b0;
                    rem_d       = raw_len;
                    state_d     = (raw_len != '0) ? S_PAYLOAD : S_HEADER;
                end
            end
            S_PAYLOAD: begin
                // only a free slot grants credit; a same-cycle pop does not count
                credit = !fifo_full;
                if (rx_i && !fifo_full) begin
                    push      = 1'b1;
                    push_last = (rem_q == 32'd1);
                    rem_d     = rem_q - 32'd1;
                    if (rem_q == 32'd1) state_d = S_HEADER;
                end
            end
            S_DISCARD: begin
                credit = 1'b1;
                if (rx_i) begin
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) state_d = S_HEADER;
                end
            end
            default: state_d = S_HEADER;
        endcase
    end

    // Payload FIFO pointer/occupancy and storage update
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push) begin
            mem_d[wr_q] = '{last: push_last, data: data_i};
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) rd_d = rd_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_HEADER;
            cnt_q       <= '0;
            rem_q       <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            err_q       <= 1'b0;
            mem_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
        end
    end

    // Service classification against the known raw service codes
    always_comb begin
        svc_known_o = 1'b0;
        case (service_o)
            32'h40, 32'h41, 32'h42, 32'h43, 32'h45: svc_known_o = 1'b1;
            default:                                svc_known_o = 1'b0;
        endcase
    end

    // No flits are taken while reset is held
    assign credit_o    = credit && !rst_i;
    assign hdr_valid_o = hdr_valid_q;
    assign hdr_o       = hdr_q;
    assign service_o   = hdr_q[2];
    assign pld_len_o   = hdr_valid_q ? raw_len : '0;
    assign err_size_o  = err_q;
    assign pld_valid_o = (occ_q != '0);
    assign pld_data_o  = pld_valid_o ? mem_q[rd_q].data : '0;
    assign pld_last_o  = pld_valid_o && mem_q[rd_q].last;

endmodule
